reg_bank_arbiter: RTL and testbench

REG_BANK_ARBITER -- requirements
Module: reg_bank_arbiter

---
 rtl/reg_bank_arbiter.sv | 171 +++++++++++++++++
 tb/tb_reg_bank_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_arbiter.sv
// reg_bank_arbiter
//   Two-requester arbiter in front of a single-read/single-write register bank.
//   After reset release the bank is cleared (one register per cycle). After that,
//   IDLE picks one requester per access, with round-robin on ties. GRANT issues
//   the bank access for one cycle.
//   Every output is registered.
//
// Ports
//   clk, rst                 clock; asynchronous active-low reset
//   req0/1, we0/1            request and write-enable from each requester
//   addr0/1, wdat0/1         target register and write data per requester
//   gnt0/1                   one-cycle grant pulse
//   rvalid0/1, rdat0/1       read-data-valid pulse and held read data
//   bank_addrR, bank_datR    bank read port (combinational data return)
//   bank_addrW, bank_datW    bank write port address/data
//   bank_RegWrite            bank write enable, sampled by the bank on clk
//   init_done                set once the clear sequence has finished
module reg_bank_arbiter #(
  parameter int DAT_W  = 4,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DAT_W-1:0]  wdat0,
  input  logic [DAT_W-1:0]  wdat1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DAT_W-1:0]  rdat0,
  output logic [DAT_W-1:0]  rdat1,
  output logic [ADDR_W-1:0] bank_addrR,
  input  logic [DAT_W-1:0]  bank_datR,
  output logic [ADDR_W-1:0] bank_addrW,
  output logic [DAT_W-1:0]  bank_datW,
  output logic              bank_RegWrite,
  output logic              init_done
);

  typedef enum logic [1:0] {INIT, IDLE, GRANT} stateT;

  // Clear counter runs 0..DEPTH; the extra value marks "all registers written".
  localparam logic [ADDR_W:0] CLR_END = (ADDR_W+1)'(2**ADDR_W);

  stateT             state, stateNxt;
  logic [ADDR_W:0]   clrCnt, clrCntNxt;
  logic              lastGnt, lastGntNxt;   // 1 = requester 1 was granted last
  logic              curRead, curReadNxt;   // access in GRANT is a read

  logic              gnt0Nxt, gnt1Nxt, rvalid0Nxt, rvalid1Nxt;
  logic [DAT_W-1:0]  rdat0Nxt, rdat1Nxt, datWNxt;
  logic [ADDR_W-1:0] addrRNxt, addrWNxt;
  logic              regWriteNxt, initDoneNxt;

  logic              pick1;
  logic              selWe;
  logic [ADDR_W-1:0] selAddr;
  logic [DAT_W-1:0]  selDat;

  always_comb begin
    stateNxt    = state;
    clrCntNxt   = clrCnt;
    lastGntNxt  = lastGnt;
    curReadNxt  = curRead;
    gnt0Nxt     = 1'b0;
    gnt1Nxt     = 1'b0;
    rvalid0Nxt  = 1'b0;
    rvalid1Nxt  = 1'b0;
    rdat0Nxt    = rdat0;
    rdat1Nxt    = rdat1;
    addrRNxt    = bank_addrR;
    addrWNxt    = bank_addrW;
    datWNxt     = bank_datW;
    regWriteNxt = 1'b0;
    initDoneNxt = init_done;
    // Requester 1 wins when alone, or on a tie when requester 0 went last.
    pick1       = req1 && (!req0 || !lastGnt);
    selWe       = pick1 ? we1   : we0;
    selAddr     = pick1 ? addr1 : addr0;
    selDat      = pick1 ? wdat1 : wdat0;

    case (state)
      INIT: begin
        if (clrCnt == CLR_END) begin
          stateNxt    = IDLE;
          initDoneNxt = 1'b1;
        end else begin
          regWriteNxt = 1'b1;
          addrWNxt    = clrCnt[ADDR_W-1:0];
          datWNxt     = '0;
          clrCntNxt   = clrCnt + 1'b1;
        end
      end
      IDLE: begin
        if (req0 || req1) begin
          stateNxt   = GRANT;
          lastGntNxt = pick1;
          gnt0Nxt    = !pick1;
          gnt1Nxt    = pick1;
          addrRNxt   = selAddr;
          curReadNxt = !selWe;
          if (selWe) begin
            regWriteNxt = 1'b1;
            addrWNxt    = selAddr;
            datWNxt     = selDat;
          end
        end
      end
      GRANT: begin
        // Read data is taken from the bank while bank_addrR holds the winner's address.
        stateNxt = IDLE;
        if (curRead) begin
          if (gnt1) begin
            rdat1Nxt   = bank_datR;
            rvalid1Nxt = 1'b1;
          end else begin
            rdat0Nxt   = bank_datR;
            rvalid0Nxt = 1'b1;
          end
        end
      end
      default: stateNxt = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= INIT;
      clrCnt        <= '0;
      lastGnt       <= 1'b1;
      curRead       <= 1'b0;
      gnt0          <= 1'b0;
      gnt1          <= 1'b0;
      rvalid0       <= 1'b0;
      rvalid1       <= 1'b0;
      rdat0         <= '0;
      rdat1         <= '0;
      bank_addrR    <= '0;
      bank_addrW    <= '0;
      bank_datW     <= '0;
      bank_RegWrite <= 1'b0;
      init_done     <= 1'b0;
    end else begin
      state         <= stateNxt;
      clrCnt        <= clrCntNxt;
      lastGnt       <= lastGntNxt;
      curRead       <= curReadNxt;
      gnt0          <= gnt0Nxt;
      gnt1          <= gnt1Nxt;
      rvalid0       <= rvalid0Nxt;
      rvalid1       <= rvalid1Nxt;
      rdat0         <= rdat0Nxt;
      rdat1         <= rdat1Nxt;
      bank_addrR    <= addrRNxt;
      bank_addrW    <= addrWNxt;
      bank_datW     <= datWNxt;
      bank_RegWrite <= regWriteNxt;
      init_done     <= initDoneNxt;
    end
  end

  gntExclusive: assert property (@(posedge clk) disable iff (!rst) !(gnt0 && gnt1));
  gntOneCycle:  assert property (@(posedge clk) disable iff (!rst) (gnt0 || gnt1) |=> !(gnt0 || gnt1));

endmodule

// File: tb/tb_reg_bank_arbiter.sv
module tb_reg_bank_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1, we0, we1;
  logic [3:0] addr0, addr1, wdat0, wdat1;
  logic       gnt0, gnt1, rvalid0, rvalid1;
  logic [3:0] rdat0, rdat1;
  logic [3:0] bankAddrR, bankDatR, bankAddrW, bankDatW;
  logic       bankRegWrite, initDone;

  logic       preload;
  logic [3:0] mem [16];
  int         checks = 0;
  int         errors = 0;
  bit         seen;
  logic [1:0] expG [8] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};

  always #5 clk = ~clk;

  reg_bank_arbiter #(.DAT_W(4), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdat0(wdat0), .wdat1(wdat1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdat0(rdat0), .rdat1(rdat1),
    .bank_addrR(bankAddrR), .bank_datR(bankDatR),
    .bank_addrW(bankAddrW), .bank_datW(bankDatW),
    .bank_RegWrite(bankRegWrite), .init_done(initDone)
  );

  // Register bank: preloaded with a non-zero pattern so the clear is observable.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) mem[i] <= 4'hA;
    end else if (bankRegWrite) begin
      mem[bankAddrW] <= bankDatW;
    end
  end
  assign bankDatR = mem[bankAddrR];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // who: 0 = gnt0, 1 = gnt1, 2 = init_done, 3 = either grant
  task automatic waitFor(input int who, input int maxCyc, output bit found);
    found = 1'b0;
    for (int i = 0; i < maxCyc; i++) begin
      @(posedge clk); #1;
      if ((who == 0 && gnt0) || (who == 1 && gnt1) || (who == 2 && initDone) ||
          (who == 3 && (gnt0 || gnt1))) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  function automatic logic [31:0] outsVec();
    return {6'd0, gnt0, gnt1, rvalid0, rvalid1, rdat0, rdat1,
            bankAddrR, bankAddrW, bankDatW, bankRegWrite, initDone};
  endfunction

  always @(negedge clk) chk("gnt_excl", 32'(gnt0 & gnt1), 0);

  initial begin
    rst = 1'b0; preload = 1'b1;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = 0; addr1 = 0; wdat0 = 0; wdat1 = 0;
    repeat (2) @(posedge clk);
    #1 preload = 1'b0;
    chk("rst_outs", outsVec(), 0);

    // Partial clear, then reset at address 8.
    @(negedge clk) rst = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      chk("clrA_we", 32'(bankRegWrite), 1);
      chk("clrA_addr", 32'(bankAddrW), 32'(k - 1));
    end
    rst = 1'b0;
    #1 chk("abort_outs", outsVec(), 0);

    // Full clear with a read request from requester 1 pending throughout.
    repeat (2) @(negedge clk);
    rst = 1'b1; req1 = 1; we1 = 0; addr1 = 7;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      chk("clr_we", 32'(bankRegWrite), 1);
      chk("clr_addr", 32'(bankAddrW), 32'(k - 1));
      chk("clr_dat", 32'(bankDatW), 0);
      chk("clr_nognt", 32'(gnt1), 0);
      chk("clr_notdone", 32'(initDone), 0);
    end
    @(posedge clk); #1;
    chk("init_we", 32'(bankRegWrite), 0);
    chk("init_done", 32'(initDone), 1);
    chk("init_nognt", 32'(gnt1), 0);
    waitFor(1, 2, seen);
    chk("init_gnt1", 32'(seen), 1);
    chk("init_rd_addrR", 32'(bankAddrR), 7);
    chk("init_rd_we", 32'(bankRegWrite), 0);
    @(posedge clk); #1; req1 = 0;
    chk("init_rvalid1", 32'(rvalid1), 1);
    chk("init_rdat1", 32'(rdat1), 0);

    // Read of an unwritten register.
    @(negedge clk) begin req0 = 1; we0 = 0; addr0 = 15; end
    waitFor(0, 3, seen);
    chk("rd15_gnt0", 32'(seen), 1);
    @(posedge clk); #1; req0 = 0;
    chk("rd15_rvalid0", 32'(rvalid0), 1);
    chk("rd15_rdat0", 32'(rdat0), 0);
    @(posedge clk); #1;
    chk("rd15_rvalid_pulse", 32'(rvalid0), 0);
    chk("rd15_hold", 32'(rdat0), 0);

    // Write 9 to reg 3 from requester 0, read back from requester 1.
    @(negedge clk) begin req0 = 1; we0 = 1; addr0 = 3; wdat0 = 9; end
    waitFor(0, 3, seen);
    chk("wr3_gnt0", 32'(seen), 1);
    chk("wr3_we", 32'(bankRegWrite), 1);
    chk("wr3_addrW", 32'(bankAddrW), 3);
    chk("wr3_datW", 32'(bankDatW), 9);
    @(posedge clk); #1; req0 = 0;
    chk("wr3_gnt_pulse", 32'(gnt0), 0);
    chk("wr3_we_pulse", 32'(bankRegWrite), 0);
    @(negedge clk) begin req1 = 1; we1 = 0; addr1 = 3; end
    waitFor(1, 3, seen);
    chk("rd3_gnt1", 32'(seen), 1);
    chk("rd3_we", 32'(bankRegWrite), 0);
    chk("rd3_addrR", 32'(bankAddrR), 3);
    @(posedge clk); #1; req1 = 0;
    chk("rd3_rvalid1", 32'(rvalid1), 1);
    chk("rd3_rdat1", 32'(rdat1), 9);
    @(posedge clk); #1;
    chk("rd3_rvalid_pulse", 32'(rvalid1), 0);
    chk("rd3_hold", 32'(rdat1), 9);
    chk("rdat0_hold2", 32'(rdat0), 0);

    // Both requesters held: writes 0->5 and 1->6 alternate with an idle cycle between.
    @(negedge clk) begin
      req0 = 1; we0 = 1; addr0 = 0; wdat0 = 5;
      req1 = 1; we1 = 1; addr1 = 1; wdat1 = 6;
    end
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("tie_gnt", 32'({gnt1, gnt0}), 32'(expG[i]));
      if (expG[i] == 2'b01) begin
        chk("tie_we0", 32'(bankRegWrite), 1);
        chk("tie_addrW0", 32'(bankAddrW), 0);
        chk("tie_datW0", 32'(bankDatW), 5);
      end else if (expG[i] == 2'b10) begin
        chk("tie_we1", 32'(bankRegWrite), 1);
        chk("tie_addrW1", 32'(bankAddrW), 1);
        chk("tie_datW1", 32'(bankDatW), 6);
      end else begin
        chk("tie_idle_we", 32'(bankRegWrite), 0);
      end
    end
    req0 = 0; req1 = 0;
    @(negedge clk) begin req0 = 1; we0 = 0; addr0 = 1; end
    waitFor(0, 3, seen);
    chk("rd1_gnt0", 32'(seen), 1);
    @(posedge clk); #1; req0 = 0;
    chk("rd1_rdat0", 32'(rdat0), 6);

    // Reset again with both reads pending: clear restarts, requester 0 wins the first tie.
    @(negedge clk) rst = 1'b0;
    #1 chk("rst2_outs", outsVec(), 0);
    @(negedge clk) begin
      rst = 1'b1;
      req0 = 1; we0 = 0; addr0 = 0;
      req1 = 1; we1 = 0; addr1 = 1;
    end
    @(posedge clk); #1;
    chk("restart_we", 32'(bankRegWrite), 1);
    chk("restart_addr", 32'(bankAddrW), 0);
    waitFor(2, 20, seen);
    chk("rst2_init_done", 32'(seen), 1);
    waitFor(3, 3, seen);
    chk("rst2_any_gnt", 32'(seen), 1);
    chk("rst2_first_tie", 32'({gnt1, gnt0}), 1);
    @(posedge clk); #1; req0 = 0;
    chk("rst2_rvalid0", 32'(rvalid0), 1);
    chk("rst2_rdat0", 32'(rdat0), 0);
    waitFor(1, 2, seen);
    chk("rst2_loser_gnt1", 32'(seen), 1);
    @(posedge clk); #1; req1 = 0;
    chk("rst2_rvalid1", 32'(rvalid1), 1);
    chk("rst2_rdat1", 32'(rdat1), 0);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
